pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Next-generation program-counter block for the MIPS core. Owns the architectural PC register and computes each next fetch address.
- Supports sequential, conditional-branch, J/JAL, JR, exception-vector and ERET flows, plus a pipeline stall.
- Captures EPC, and provides an optional branch-delay-slot mode.
- Sits between the controller (npcop, taken, exception strobes) and instruction memory (pc).

Parameters:
- ADDR_W, 32, PC/address width; minimum 28.
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VEC, 32'h0000_4180, exception handler entry address.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC; no state update.
- npcop  in  3  000 seq, 001 branch, 010 J, 011 JAL, 100 JR; 101-111 reserved (treated as seq).
- br_taken  in  1  branch condition; qualifies npcop=001.
- imm16  in  16  branch offset, in words.
- imm26  in  26  jump index.
- rs_val  in  ADDR_W  JR target register value.
- exc_req  in  1  synchronous exception request.
- eret  in  1  return from exception.
- pc  out  ADDR_W  current fetch address.
- pc_plus8  out  ADDR_W  link value for JAL: pc+8 with delay slot, pc+4 without.
- epc  out  ADDR_W  saved exception PC.
- exc_bd  out  1  exception was taken in a delay slot.
- addr_err  out  1  one-cycle pulse: JR target misaligned.

Behaviour:
- Reset (asynchronous, rst_n low):
  - pc=RESET_PC, epc=0, exc_bd=0, addr_err=0.
  - Delay-slot state cleared.
  - Takes effect mid-operation, discarding any pending redirect.
- All updates occur on the rising clk edge. pc_plus8 is combinational from pc.
- Arithmetic is modulo 2^ADDR_W; wrap-around is silent.
  - Branch target = pc + 4 + (sign_ext(imm16) << 2).
  - J/JAL target = {pc_plus4[ADDR_W-1:28], imm26, 2'b00}.
  - JR target = rs_val.
- Priority per cycle, highest first: exc_req, eret, stall, npcop.
  - exc_req: epc <= pc, pc <= EXC_VEC, exc_bd <= 0. Overrides stall.
  - eret (without exc_req): pc <= epc. Overrides stall.
  - stall: pc, epc and slot state hold. addr_err is 0.
  - npcop=001 with br_taken=0: sequential.
- Misaligned JR (rs_val[1:0] != 0):
  - Treated as an exception: epc <= pc, pc <= EXC_VEC.
  - addr_err pulses high for exactly one cycle.
- eret and exc_req in the same cycle: exc_req wins and eret is dropped.
- Reserved npcop values: pc <= pc + 4, no error flagged.
- Core FSM (without the delay-slot macro) has a single state, RUN.

Optional Feature:
- Macro: MIPS_DELAY_SLOT_EN.
- Defined: FSM has two states, RUN and SLOT.
  - RUN, on a redirecting npcop (taken branch, J, JAL, valid JR): pc <= pc + 4, tgt_q <= target, go to SLOT.
  - SLOT, on the next non-stalled cycle: pc <= tgt_q, return to RUN. npcop is ignored in SLOT.
  - Stall in SLOT holds both the state and tgt_q.
  - exc_req in SLOT: epc <= pc - 4 (the branch), exc_bd <= 1, pc <= EXC_VEC, pending target discarded, return to RUN.
  - Link value: pc_plus8 = pc + 8.
- Undefined: redirects take effect on the next edge, no SLOT state, exc_bd tied to 0, pc_plus8 = pc + 4.

Test Plan:
- Reset then 3 cycles npcop=000 -> pc = 3000, 3004, 3008, 300C.
- pc=3010, npcop=001, br_taken=1, imm16=FFFC -> pc=3004. With the macro: pc=3014, then 3004.
- pc=3020, npcop=011, imm26=0000C40 -> pc=00003100; pc_plus8 = 3024 without the macro, 3028 with it.
- npcop=100, rs_val=00003102 at pc=3040 -> addr_err pulses 1 cycle, epc=3040, pc=4180. Then eret -> pc=3040.
- stall=1 for 2 cycles during npcop=010 -> pc holds. exc_req asserted together with stall -> pc=4180 next edge.
- Macro on: taken branch at 3050 then exc_req in the slot cycle -> epc=3050, exc_bd=1, pc=4180. rst_n low mid-slot -> pc=3000 asynchronously, slot cleared.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: program-counter block for the MIPS core.
// Holds the architectural PC and computes each next fetch address. It supports
// sequential, branch, J/JAL, JR, exception-vector and ERET flows, plus a stall.
// It also captures EPC and flags misaligned JR targets.
//
// Optional feature: define MIPS_DELAY_SLOT_EN to enable branch-delay-slot mode.
// In that mode a redirect first fetches pc+4 (the slot), and the FSM moves to
// SLOT. The stored target is loaded on the next non-stalled cycle. With the
// macro undefined, redirects take effect on the next edge. The FSM then has a
// single RUN state and exc_bd is tied to 0.
module pc_unit #(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(32'h0000_3000),
    parameter logic [ADDR_W-1:0]  EXC_VEC  = ADDR_W'(32'h0000_4180)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [2:0]        npcop,
    input  logic              br_taken,
    input  logic [15:0]       imm16,
    input  logic [25:0]       imm26,
    input  logic [ADDR_W-1:0] rs_val,
    input  logic              exc_req,
    input  logic              eret,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus8,
    output logic [ADDR_W-1:0] epc,
    output logic              exc_bd,
    output logic              addr_err
);

    // Next-PC operation encoding driven by the controller; 101-111 act as SEQ.
    typedef enum logic [2:0] {
        NPC_SEQ = 3'b000,
        NPC_BR  = 3'b001,
        NPC_J   = 3'b010,
        NPC_JAL = 3'b011,
        NPC_JR  = 3'b100
    } npcop_e;

`ifdef MIPS_DELAY_SLOT_EN
    typedef enum logic {RUN, SLOT} state_e;
`else
    typedef enum logic {RUN} state_e;
`endif

    localparam logic [ADDR_W-1:0] FOUR  = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] EIGHT = ADDR_W'(8);

    state_e            state;
    logic [ADDR_W-1:0] pc_plus4;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] j_target;
    logic [ADDR_W-1:0] redirect_target;
    logic              redirect;
    logic              jr_misaligned;

`ifdef MIPS_DELAY_SLOT_EN
    logic [ADDR_W-1:0] tgt_q;
    logic              exc_bd_q;
`endif

    assign pc_plus4  = pc + FOUR;

    // Branch offset is in words: sign-extend and scale by 4 before adding.
    assign br_target = pc_plus4 + {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};

    // Jump target keeps the upper region bits of pc+4 above bit 27.
    generate
        if (ADDR_W > 28) begin : g_jump_region
            assign j_target = {pc_plus4[ADDR_W-1:28], imm26, 2'b00};
        end else begin : g_jump_full
            assign j_target = {imm26, 2'b00};
        end
    endgenerate

`ifdef MIPS_DELAY_SLOT_EN
    assign pc_plus8 = pc + EIGHT;
    assign exc_bd   = exc_bd_q;
`else
    assign pc_plus8 = pc + FOUR;
    assign exc_bd   = 1'b0;
`endif

    // Decode npcop into a redirect request, its target, and the JR alignment fault.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can leave
        // it unassigned, which would otherwise infer a latch.
        redirect        = 1'b0;
        redirect_target = pc_plus4;
        jr_misaligned   = 1'b0;
        case (npcop)
            NPC_BR: begin
                if (br_taken) begin
                    redirect        = 1'b1;
                    redirect_target = br_target;
                end
            end
            NPC_J, NPC_JAL: begin
                redirect        = 1'b1;
                redirect_target = j_target;
            end
            NPC_JR: begin
                if (rs_val[1:0] != 2'b00) begin
                    jr_misaligned = 1'b1;
                end else begin
                    redirect        = 1'b1;
                    redirect_target = rs_val;
                end
            end
            default: ;
        endcase
    end

    // PC/EPC/slot state machine. Priority: exc_req, eret, stall, then npcop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            pc       <= RESET_PC;
            epc      <= '0;
            addr_err <= 1'b0;
`ifdef MIPS_DELAY_SLOT_EN
            exc_bd_q <= 1'b0;
            // NOTE: tgt_q is plain datapath, but it is reset so that an
            // asynchronous reset leaves no stale redirect behind.
            tgt_q    <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so
            // every right-hand side sees the pre-edge values (e.g. epc <= pc).
            addr_err <= 1'b0;
            if (exc_req) begin
                pc    <= EXC_VEC;
                state <= RUN;
`ifdef MIPS_DELAY_SLOT_EN
                if (state == SLOT) begin
                    // The faulting slot's branch sits one word behind pc.
                    epc      <= pc - FOUR;
                    exc_bd_q <= 1'b1;
                end else begin
                    epc      <= pc;
                    exc_bd_q <= 1'b0;
                end
`else
                epc   <= pc;
`endif
            end else if (eret) begin
                pc    <= epc;
                state <= RUN;
            end else if (!stall) begin
                case (state)
`ifdef MIPS_DELAY_SLOT_EN
                    SLOT: begin
                        // The delay slot has been fetched; npcop is ignored here.
                        pc    <= tgt_q;
                        state <= RUN;
                    end
`endif
                    default: begin
                        if (jr_misaligned) begin
                            epc      <= pc;
                            pc       <= EXC_VEC;
                            addr_err <= 1'b1;
`ifdef MIPS_DELAY_SLOT_EN
                            exc_bd_q <= 1'b0;
`endif
                        end else if (redirect) begin
`ifdef MIPS_DELAY_SLOT_EN
                            pc    <= pc_plus4;
                            tgt_q <= redirect_target;
                            state <= SLOT;
`else
                            pc    <= redirect_target;
`endif
                        end else begin
                            pc <= pc_plus4;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: self-checking bench for pc_unit.
// Directed scenarios check fixed expected addresses. A randomized run checks
// the DUT against a behavioural model of the next-PC rules. Define
// MIPS_DELAY_SLOT_EN for the bench and the RTL together to cover slot mode.
module tb_pc_unit;

`ifdef MIPS_DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] LINK     = DS ? 32'd8 : 32'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [2:0]  npcop = 3'd0;
    logic        br_taken = 1'b0;
    logic [15:0] imm16 = 16'd0;
    logic [25:0] imm26 = 26'd0;
    logic [31:0] rs_val = 32'd0;
    logic        exc_req = 1'b0;
    logic        eret = 1'b0;
    logic [31:0] pc;
    logic [31:0] pc_plus8;
    logic [31:0] epc;
    logic        exc_bd;
    logic        addr_err;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic [31:0] m_tgt;
    bit          m_bd;
    bit          m_err;
    bit          m_slot;

    pc_unit #(
        .ADDR_W   (32),
        .RESET_PC (RESET_PC),
        .EXC_VEC  (EXC_VEC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall    (stall),
        .npcop    (npcop),
        .br_taken (br_taken),
        .imm16    (imm16),
        .imm26    (imm26),
        .rs_val   (rs_val),
        .exc_req  (exc_req),
        .eret     (eret),
        .pc       (pc),
        .pc_plus8 (pc_plus8),
        .epc      (epc),
        .exc_bd   (exc_bd),
        .addr_err (addr_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pc   = RESET_PC;
        m_epc  = 32'd0;
        m_tgt  = 32'd0;
        m_bd   = 1'b0;
        m_err  = 1'b0;
        m_slot = 1'b0;
    endtask

    // One clock edge worth of next-PC rules, computed from the current inputs.
    task automatic model_edge();
        logic [31:0] seq;
        logic [31:0] tgt;
        int          off;
        bit          redir;
        seq   = m_pc + 32'd4;
        tgt   = seq;
        redir = 1'b0;
        off   = $signed(imm16);
        m_err = 1'b0;
        if (exc_req) begin
            if (m_slot) begin
                m_epc = m_pc - 32'd4;
                m_bd  = 1'b1;
            end else begin
                m_epc = m_pc;
                m_bd  = 1'b0;
            end
            m_pc   = EXC_VEC;
            m_slot = 1'b0;
        end else if (eret) begin
            m_pc   = m_epc;
            m_slot = 1'b0;
        end else if (stall) begin
            m_pc = m_pc;
        end else if (m_slot) begin
            m_pc   = m_tgt;
            m_slot = 1'b0;
        end else begin
            case (npcop)
                3'd1: if (br_taken) begin redir = 1'b1; tgt = seq + off * 4; end
                3'd2, 3'd3: begin redir = 1'b1; tgt = {seq[31:28], imm26, 2'b00}; end
                3'd4: begin
                    if (rs_val[1:0] != 2'b00) m_err = 1'b1;
                    else begin redir = 1'b1; tgt = rs_val; end
                end
                default: ;
            endcase
            if (m_err) begin
                m_epc = m_pc;
                m_bd  = 1'b0;
                m_pc  = EXC_VEC;
            end else if (!redir) begin
                m_pc = seq;
            end else if (DS) begin
                m_tgt  = tgt;
                m_slot = 1'b1;
                m_pc   = seq;
            end else begin
                m_pc = tgt;
            end
        end
    endtask

    // Advance one clock edge, update the model, settle 1 time unit past the edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        stall    = 1'b0;
        npcop    = 3'd0;
        br_taken = 1'b0;
        exc_req  = 1'b0;
        eret     = 1'b0;
    endtask

    // Move the PC to an aligned address via JR (plus the slot cycle in slot mode).
    task automatic goto_pc(input logic [31:0] addr);
        idle();
        npcop  = 3'd4;
        rs_val = addr;
        cycle();
        if (DS) begin
            npcop = 3'd0;
            cycle();
        end
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        model_reset();
        #12;
        n_cmp++; if (pc !== RESET_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", pc, RESET_PC); end
        n_cmp++; if (epc !== 32'd0) begin n_fail++; $display("FAIL reset_epc: got %h want 0", epc); end
        n_cmp++; if (exc_bd !== 1'b0) begin n_fail++; $display("FAIL reset_exc_bd: got %b want 0", exc_bd); end
        n_cmp++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err: got %b want 0", addr_err); end
        n_cmp++; if (pc_plus8 !== RESET_PC + LINK) begin n_fail++; $display("FAIL reset_link: got %h want %h", pc_plus8, RESET_PC + LINK); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        idle();
        for (int i = 1; i <= 4; i++) begin
            cycle();
            exp = RESET_PC + 32'(4 * i);
            n_cmp++; if (pc !== exp) begin n_fail++; $display("FAIL seq_%0d: pc got %h want %h", i, pc, exp); end
        end
    endtask

    task automatic test_branch();
        logic [31:0] exp;
        idle();
        npcop = 3'd1; br_taken = 1'b1; imm16 = 16'hFFFC;
        cycle();
        exp = DS ? 32'h3014 : 32'h3004;
        n_cmp++; if (pc !== exp) begin n_fail++; $display("FAIL branch_taken: pc got %h want %h", pc, exp); end
        idle();
        cycle();
        exp = DS ? 32'h3004 : 32'h3008;
        n_cmp++; if (pc !== exp) begin n_fail++; $display("FAIL branch_after: pc got %h want %h", pc, exp); end
        npcop = 3'd1; br_taken = 1'b0;
        cycle();
        exp = DS ? 32'h3008 : 32'h300C;
        n_cmp++; if (pc !== exp) begin n_fail++; $display("FAIL branch_not_taken: pc got %h want %h", pc, exp); end
        idle();
    endtask

    task automatic test_jal();
        logic [31:0] exp;
        goto_pc(32'h3020);
        n_cmp++; if (pc !== 32'h3020) begin n_fail++; $display("FAIL jal_setup: pc got %h want 3020", pc); end
        exp = DS ? 32'h3028 : 32'h3024;
        n_cmp++; if (pc_plus8 !== exp) begin n_fail++; $display("FAIL jal_link: got %h want %h", pc_plus8, exp); end
        npcop = 3'd3; imm26 = 26'h0000C40;
        cycle();
        exp = DS ? 32'h3024 : 32'h3100;
        n_cmp++; if (pc !== exp) begin n_fail++; $display("FAIL jal_first: pc got %h want %h", pc, exp); end
        idle();
        cycle();
        exp = DS ? 32'h3100 : 32'h3104;
        n_cmp++; if (pc !== exp) begin n_fail++; $display("FAIL jal_second: pc got %h want %h", pc, exp); end
    endtask

    task automatic test_jr_misaligned();
        goto_pc(32'h3040);
        npcop = 3'd4; rs_val = 32'h0000_3102;
        cycle();
        n_cmp++; if (addr_err !== 1'b1) begin n_fail++; $display("FAIL jr_addr_err: got %b want 1", addr_err); end
        n_cmp++; if (epc !== 32'h3040) begin n_fail++; $display("FAIL jr_epc: got %h want 3040", epc); end
        n_cmp++; if (pc !== EXC_VEC) begin n_fail++; $display("FAIL jr_pc: got %h want %h", pc, EXC_VEC); end
        n_cmp++; if (exc_bd !== 1'b0) begin n_fail++; $display("FAIL jr_exc_bd: got %b want 0", exc_bd); end
        idle();
        eret = 1'b1;
        cycle();
        n_cmp++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL jr_pulse_end: got %b want 0", addr_err); end
        n_cmp++; if (pc !== 32'h3040) begin n_fail++; $display("FAIL eret_pc: got %h want 3040", pc); end
        idle();
    endtask

    task automatic test_stall();
        goto_pc(32'h3060);
        npcop = 3'd2; imm26 = 26'h0000123; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++; if (pc !== 32'h3060) begin n_fail++; $display("FAIL stall_hold_%0d: pc got %h want 3060", i, pc); end
        end
        exc_req = 1'b1;
        cycle();
        n_cmp++; if (pc !== EXC_VEC) begin n_fail++; $display("FAIL stall_exc_pc: got %h want %h", pc, EXC_VEC); end
        n_cmp++; if (epc !== 32'h3060) begin n_fail++; $display("FAIL stall_exc_epc: got %h want 3060", epc); end
        idle();
    endtask

    task automatic test_reserved();
        logic [31:0] exp;
        idle();
        rs_val = 32'h0000_0003;
        for (int op = 5; op <= 7; op++) begin
            npcop = 3'(op);
            exp   = m_pc + 32'd4;
            cycle();
            n_cmp++; if (pc !== exp) begin n_fail++; $display("FAIL reserved_%0d: pc got %h want %h", op, pc, exp); end
            n_cmp++; if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reserved_err_%0d: got %b want 0", op, addr_err); end
        end
        idle();
    endtask

`ifdef MIPS_DELAY_SLOT_EN
    task automatic test_slot();
        goto_pc(32'h3050);
        npcop = 3'd1; br_taken = 1'b1; imm16 = 16'h0008;
        cycle();
        n_cmp++; if (pc !== 32'h3054) begin n_fail++; $display("FAIL slot_fetch: pc got %h want 3054", pc); end
        idle();
        exc_req = 1'b1;
        cycle();
        n_cmp++; if (epc !== 32'h3050) begin n_fail++; $display("FAIL slot_epc: got %h want 3050", epc); end
        n_cmp++; if (exc_bd !== 1'b1) begin n_fail++; $display("FAIL slot_exc_bd: got %b want 1", exc_bd); end
        n_cmp++; if (pc !== EXC_VEC) begin n_fail++; $display("FAIL slot_exc_pc: got %h want %h", pc, EXC_VEC); end
        goto_pc(32'h3080);
        npcop = 3'd2; imm26 = 26'h0000D00;
        cycle();
        idle();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cycle();
            n_cmp++; if (pc !== 32'h3084) begin n_fail++; $display("FAIL slot_stall_%0d: pc got %h want 3084", i, pc); end
        end
        stall = 1'b0; npcop = 3'd1; br_taken = 1'b1;
        cycle();
        n_cmp++; if (pc !== 32'h3400) begin n_fail++; $display("FAIL slot_target: pc got %h want 3400", pc); end
        idle();
    endtask
`endif

    task automatic test_async_reset();
        goto_pc(32'h3070);
        npcop = 3'd1; br_taken = 1'b1; imm16 = 16'h0010;
        cycle();
        idle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (pc !== RESET_PC) begin n_fail++; $display("FAIL async_reset_pc: got %h want %h", pc, RESET_PC); end
        n_cmp++; if (exc_bd !== 1'b0) begin n_fail++; $display("FAIL async_reset_bd: got %b want 0", exc_bd); end
        #2;
        rst_n = 1'b1;
        cycle();
        n_cmp++; if (pc !== 32'h3004) begin n_fail++; $display("FAIL async_reset_after: pc got %h want 3004", pc); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            exc_req  = ($urandom_range(0, 19) == 0);
            eret     = ($urandom_range(0, 19) == 0);
            stall    = ($urandom_range(0, 5) == 0);
            npcop    = 3'($urandom_range(0, 7));
            br_taken = 1'($urandom);
            imm16    = 16'($urandom);
            imm26    = 26'($urandom);
            rs_val   = $urandom;
            if ($urandom_range(0, 3) != 0) rs_val[1:0] = 2'b00;
            cycle();
            n_cmp++; if (pc !== m_pc) begin n_fail++; $display("FAIL rand_pc[%0d]: got %h want %h", i, pc, m_pc); end
            n_cmp++; if (epc !== m_epc) begin n_fail++; $display("FAIL rand_epc[%0d]: got %h want %h", i, epc, m_epc); end
            n_cmp++; if (exc_bd !== m_bd) begin n_fail++; $display("FAIL rand_bd[%0d]: got %b want %b", i, exc_bd, m_bd); end
            n_cmp++; if (addr_err !== m_err) begin n_fail++; $display("FAIL rand_err[%0d]: got %b want %b", i, addr_err, m_err); end
            n_cmp++; if (pc_plus8 !== m_pc + LINK) begin n_fail++; $display("FAIL rand_link[%0d]: got %h want %h", i, pc_plus8, m_pc + LINK); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_branch();
        test_jal();
        test_jr_misaligned();
        test_stall();
        test_reserved();
`ifdef MIPS_DELAY_SLOT_EN
        test_slot();
`endif
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
